// File: rtl/fetch_control_unit.sv
// Fetch sequencing controller: turns branch/stall/halt events into registered
// PC-mux, NOP-mux and flush control words, with saturating stall/flush counters.
module fetch_control_unit #(
   parameter int ADDR_W       = 16,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              stall_req,
   input  logic [3:0]        stall_len,
   input  logic              halt_req,
   input  logic              resume,
   output logic [1:0]        select_pc_mux,
   output logic [ADDR_W-1:0] branch_address,
   output logic [1:0]        select_nop_mux,
   output logic [1:0]        flush,
   output logic              busy,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   localparam logic [2:0] ST_RUN      = 3'd0;
   localparam logic [2:0] ST_REDIRECT = 3'd1;
   localparam logic [2:0] ST_FLUSH    = 3'd2;
   localparam logic [2:0] ST_STALL    = 3'd3;
   localparam logic [2:0] ST_HALT     = 3'd4;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   logic [2:0] state;
   logic [2:0] next_state;
   logic [3:0] down_cnt;
   logic [3:0] next_cnt;

   // A taken branch pre-empts every state and restarts the redirect sequence.
   always_comb begin
      next_state = state;
      next_cnt   = down_cnt;
      if (branch_taken) begin
         next_state = ST_REDIRECT;
         next_cnt   = 4'd0;
      end else begin
         case (state)
            ST_RUN: begin
               if (halt_req) begin
                  next_state = ST_HALT;
               end else if (stall_req) begin
                  next_state = ST_STALL;
                  next_cnt   = (stall_len == 4'd0) ? 4'd1 : stall_len;
               end
            end
            ST_REDIRECT: begin
               if (FLUSH_CYCLES <= 1) begin
                  next_state = ST_RUN;
               end else begin
                  next_state = ST_FLUSH;
                  next_cnt   = FLUSH_LOAD;
               end
            end
            ST_FLUSH, ST_STALL: begin
               if (down_cnt <= 4'd1) begin
                  next_state = ST_RUN;
                  next_cnt   = 4'd0;
               end else begin
                  next_cnt = down_cnt - 4'd1;
               end
            end
            ST_HALT: begin
               if (resume) next_state = ST_RUN;
            end
            default: next_state = ST_RUN;
         endcase
      end
   end

   // Outputs are decoded from the next state so they appear as registered Moore
   // outputs one cycle after the triggering input.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_RUN;
         down_cnt       <= 4'd0;
         select_pc_mux  <= 2'b00;
         branch_address <= '0;
         select_nop_mux <= 2'b00;
         flush          <= 2'b00;
         busy           <= 1'b0;
         stall_count    <= '0;
         flush_count    <= '0;
      end else begin
         state          <= next_state;
         down_cnt       <= next_cnt;
         if (branch_taken) branch_address <= branch_target;
         select_pc_mux  <= (next_state == ST_REDIRECT) ? 2'b01 : 2'b00;
         select_nop_mux <= (next_state == ST_STALL || next_state == ST_HALT) ? 2'b01 : 2'b00;
         flush          <= (next_state == ST_REDIRECT || next_state == ST_FLUSH) ? 2'b01 : 2'b00;
         busy           <= (next_state != ST_RUN);
         if (select_nop_mux == 2'b01 && stall_count != '1)
            stall_count <= stall_count + CNT_W'(1);
         if (flush == 2'b01 && flush_count != '1)
            flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule
